character_motion: RTL and testbench
===================================

# character_motion

Per-frame motion controller for the player character. It turns the movement inputs (left/right/jump) into the registered `character_x_position` / `character_y_position` pair that the character renderer consumes. Positions only change on the one-cycle `frame_tick` pulse, so the renderer sees a stable character throughout each frame. The block runs a ground/rise/fall jump state machine with integer gravity and screen-edge clamping.

## Interface
Parameters:
- `X_START`, 20: x position after reset.
- `Y_GROUND`, 100: torso-top y when standing; also the landing line.
- `X_MIN`, 3: leftmost x (keeps the left arm, at x-3, on screen).
- `X_MAX`, 309: rightmost x (keeps the right arm, at x+10, within 319).
- `Y_MIN`, 5: smallest y (keeps the head, at y-5, on screen).
- `STEP`, 1: horizontal pixels moved per tick.
- `JUMP_VEL`, 6: initial upward speed in pixels per tick (1..15).
- `MAX_FALL`, 7: terminal downward speed (1..15).

Ports:
- `clock`, in, 1: single system clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `frame_tick`, in, 1: one-cycle pulse, once per video frame.
- `move_left`, in, 1: level input; move left request.
- `move_right`, in, 1: level input; move right request.
- `jump`, in, 1: level or pulse; jump request.
- `character_x_position`, out, 9: registered x position.
- `character_y_position`, out, 9: registered y position.
- `airborne`, out, 1: high while the state is RISE or FALL.
- `frame_done`, out, 1: one-cycle pulse after each position update.

## Operation
- **Reset values:** x=`X_START`, y=`Y_GROUND`, state=GROUND, vy=0, jump_pending=0, `airborne`=0, `frame_done`=0.
- **Jump request latch (`jump_pending`):**
  - Sets on any cycle with `jump`=1 while state=GROUND.
  - Requests while RISE or FALL are ignored and are never stored.
  - Cleared on the tick that leaves GROUND.
  - The effective request on a tick is `jump | jump_pending`, so a request arriving in the same cycle as the tick is honoured.
- **Horizontal motion (each tick, in every state):**
  - `move_left` only: x = max(x-`STEP`, `X_MIN`).
  - `move_right` only: x = min(x+`STEP`, `X_MAX`).
  - Both or neither: x unchanged.
  - All arithmetic is done at 10 bits before clamping, so x never wraps.
- **State machine (advances on ticks only):**
  - GROUND: if a request is effective, go to RISE with vy=`JUMP_VEL`; y is unchanged on this tick. Otherwise stay, y=`Y_GROUND`.
  - RISE: t = y-vy, computed signed at 10 bits.
    - If t < `Y_MIN`: y=`Y_MIN`, vy=0, go to FALL.
    - Otherwise: y=t, vy=vy-1. If the new vy is 0, go to FALL.
  - FALL: t = y+vy.
    - If t ≥ `Y_GROUND`: y=`Y_GROUND`, vy=0, go to GROUND. The landing tick never sets `jump_pending`.
    - Otherwise: y=t, vy=min(vy+1, `MAX_FALL`).
- **Outputs:**
  - `airborne` is decoded from the registered state.
  - `frame_done`=1 for the single cycle after every tick edge, including ticks where nothing moves.
- **Reset mid-jump:** all registers return to their reset values immediately, without waiting for a clock edge.

## Timing
- All state changes happen on the rising `clock` edge at which `frame_tick`=1. New positions are visible from the next cycle. Latency is 1 clock.
- `frame_done` is high in exactly that next cycle. Back-to-back ticks produce back-to-back `frame_done` pulses.
- Between ticks, every output except `frame_done` is held constant. `move_*` are sampled only at the tick edge.
- A tick held high for N cycles counts as N ticks. Driving it that way is the upstream's responsibility; the block does not detect it.
- Reset dominates `frame_tick`.

## Test plan
- **Reset:** assert `resetn`=0 mid-frame → x=20, y=100, `airborne`=0, `frame_done`=0 with no clock edge needed.
- **Full jump, default parameters:** `jump` pulse, then 14 ticks.
  - Tick 1: y=100, state→RISE.
  - RISE ticks: y=94, 89, 85, 82, 80, 79.
  - FALL ticks: y=79, 80, 82, 85, 89, 94, 100.
  - After the last tick `airborne`=0.
- **Ceiling, `Y_MIN`=85:** jump → y=94, 89, 85, then clamps at 85 and enters FALL. The next FALL tick gives y=85+0, then 86.
- **Horizontal clamp:**
  - `move_left` held for 30 ticks from x=20 → x=3 and stays at 3.
  - `move_right` from x=308 → x=309, 309.
  - Both held → x unchanged.
- **Request timing:**
  - `jump` asserted while airborne, then released before landing → the block lands and stays in GROUND.
  - `jump` in the same cycle as a tick while in GROUND → RISE on that tick.
- **`frame_done`:** ticks on cycles 10, 11, and 20 → pulses on cycles 11, 12, and 21 only.

Source files
------------

// File: rtl/character_motion.sv
// Per-frame player motion: left/right stepping with edge clamps and a ground/rise/fall jump with integer gravity.
// Latency 1 clock from the frame_tick edge to updated positions; no backpressure, every tick is consumed.
module character_motion #(
  parameter int X_START  = 20,
  parameter int Y_GROUND = 100,
  parameter int X_MIN    = 3,
  parameter int X_MAX    = 309,
  parameter int Y_MIN    = 5,
  parameter int STEP     = 1,
  parameter int JUMP_VEL = 6,
  parameter int MAX_FALL = 7
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  output logic [8:0] character_x_position,
  output logic [8:0] character_y_position,
  output logic       airborne,
  output logic       frame_done
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic signed [9:0] STEP_S     = 10'(STEP);
  localparam logic signed [9:0] X_MIN_S    = 10'(X_MIN);
  localparam logic signed [9:0] X_MAX_S    = 10'(X_MAX);
  localparam logic signed [9:0] Y_MIN_S    = 10'(Y_MIN);
  localparam logic signed [9:0] Y_GROUND_S = 10'(Y_GROUND);

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic [3:0] vy_q, vy_d;
  logic       pend_q, pend_d;
  logic       airborne_q, airborne_d;
  logic       frame_done_q, frame_done_d;

  // Ten-bit signed intermediates so stepping past either edge never wraps.
  logic signed [9:0] x_left, x_right, y_up, y_down;
  assign x_left  = $signed({1'b0, x_q}) - STEP_S;
  assign x_right = $signed({1'b0, x_q}) + STEP_S;
  assign y_up    = $signed({1'b0, y_q}) - $signed({6'b0, vy_q});
  assign y_down  = $signed({1'b0, y_q}) + $signed({6'b0, vy_q});

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vy_d         = vy_q;
    pend_d       = pend_q;
    frame_done_d = frame_tick;

    // Requests are only remembered on the ground; airborne presses are dropped.
    if (state_q == GROUND && jump) pend_d = 1'b1;

    if (frame_tick) begin
      if (move_left && !move_right)
        x_d = (x_left < X_MIN_S) ? 9'(X_MIN) : x_left[8:0];
      else if (move_right && !move_left)
        x_d = (x_right > X_MAX_S) ? 9'(X_MAX) : x_right[8:0];

      case (state_q)
        GROUND: begin
          if (jump || pend_q) begin
            state_d = RISE;
            vy_d    = 4'(JUMP_VEL);
            pend_d  = 1'b0;
          end else begin
            y_d = 9'(Y_GROUND);
          end
        end
        RISE: begin
          if (y_up < Y_MIN_S) begin
            y_d     = 9'(Y_MIN);
            vy_d    = 4'd0;
            state_d = FALL;
          end else begin
            y_d  = y_up[8:0];
            vy_d = vy_q - 4'd1;
            if (vy_q == 4'd1) state_d = FALL;
          end
        end
        FALL: begin
          if (y_down >= Y_GROUND_S) begin
            y_d     = 9'(Y_GROUND);
            vy_d    = 4'd0;
            state_d = GROUND;
          end else begin
            y_d  = y_down[8:0];
            vy_d = (vy_q >= 4'(MAX_FALL)) ? 4'(MAX_FALL) : vy_q + 4'd1;
          end
        end
        default: state_d = GROUND;
      endcase
    end

    airborne_d = (state_d != GROUND);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= GROUND;
      x_q          <= 9'(X_START);
      y_q          <= 9'(Y_GROUND);
      vy_q         <= 4'd0;
      pend_q       <= 1'b0;
      airborne_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vy_q         <= vy_d;
      pend_q       <= pend_d;
      airborne_q   <= airborne_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign character_x_position = x_q;
  assign character_y_position = y_q;
  assign airborne             = airborne_q;
  assign frame_done           = frame_done_q;

endmodule

// File: tb/tb_character_motion.sv
// Randomised and directed bench for character_motion; two instances (default and low-ceiling/right-edge start).
module tb_character_motion;

  localparam int XG = 3, XM = 309, YG = 100, JV = 6, MF = 7, ST = 1;
  localparam int A_YMIN = 5, B_YMIN = 85;
  localparam int A_XS = 20, B_XS = 308;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0, move_left = 1'b0, move_right = 1'b0, jump = 1'b0;
  logic [8:0] ax, ay, bx, by;
  logic a_air, a_done, b_air, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  character_motion dut_a (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .character_x_position(ax), .character_y_position(ay),
    .airborne(a_air), .frame_done(a_done)
  );

  character_motion #(.X_START(B_XS), .Y_MIN(B_YMIN)) dut_b (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .character_x_position(bx), .character_y_position(by),
    .airborne(b_air), .frame_done(b_done)
  );

  // Behavioural reference: phase 0 ground, 1 rising, 2 falling.
  typedef struct {
    int x; int y; int vy; int phase; int want_jump; int done;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset(int xs);
    model_t m;
    m.x = xs; m.y = YG; m.vy = 0; m.phase = 0; m.want_jump = 0; m.done = 0;
    return m;
  endfunction

  function automatic model_t model_cycle(model_t m, int tick, int jp, int l, int r, int ymin);
    int t;
    m.done = tick;
    if (!tick) begin
      if (m.phase == 0 && jp != 0) m.want_jump = 1;
      return m;
    end
    if (l != 0 && r == 0) m.x = (m.x - ST < XG) ? XG : m.x - ST;
    if (r != 0 && l == 0) m.x = (m.x + ST > XM) ? XM : m.x + ST;
    if (m.phase == 0) begin
      if (jp != 0 || m.want_jump != 0) begin
        m.phase = 1; m.vy = JV; m.want_jump = 0;
      end else m.y = YG;
    end else if (m.phase == 1) begin
      t = m.y - m.vy;
      if (t < ymin) begin
        m.y = ymin; m.vy = 0; m.phase = 2;
      end else begin
        m.y = t; m.vy = m.vy - 1;
        if (m.vy == 0) m.phase = 2;
      end
    end else begin
      t = m.y + m.vy;
      if (t >= YG) begin
        m.y = YG; m.vy = 0; m.phase = 0;
      end else begin
        m.y = t; m.vy = (m.vy + 1 > MF) ? MF : m.vy + 1;
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("a_x", int'(ax), ma.x);
    chk("a_y", int'(ay), ma.y);
    chk("a_air", int'(a_air), int'(ma.phase != 0));
    chk("a_done", int'(a_done), ma.done);
    chk("b_x", int'(bx), mb.x);
    chk("b_y", int'(by), mb.y);
    chk("b_air", int'(b_air), int'(mb.phase != 0));
    chk("b_done", int'(b_done), mb.done);
  endtask

  // Called just after a rising edge; applies inputs for the next edge then checks.
  task automatic do_cycle(input int tk, input int jp, input int l, input int r);
    frame_tick = tk[0]; jump = jp[0]; move_left = l[0]; move_right = r[0];
    @(posedge clock);
    ma = model_cycle(ma, tk, jp, l, r, A_YMIN);
    mb = model_cycle(mb, tk, jp, l, r, B_YMIN);
    #1;
    check_models();
  endtask

  int a_jump_y[14] = '{100, 94, 89, 85, 82, 80, 79, 79, 80, 82, 85, 89, 94, 100};
  int b_jump_y[8]  = '{100, 94, 89, 85, 85, 85, 86, 88};

  initial begin
    ma = model_reset(A_XS);
    mb = model_reset(B_XS);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_a_x", int'(ax), 20);
    chk("rst_a_y", int'(ay), 100);
    chk("rst_b_x", int'(bx), 308);
    chk("rst_air", int'(a_air), 0);
    chk("rst_done", int'(a_done), 0);
    resetn = 1'b1;

    // Right edge clamp on B, then left edge on A, then both held.
    for (int i = 0; i < 2; i++) begin
      do_cycle(1, 0, 0, 1);
      chk("b_right_clamp", int'(bx), (i == 0) ? 309 : 309);
    end
    for (int i = 0; i < 30; i++) do_cycle(1, 0, 1, 0);
    chk("a_left_clamp", int'(ax), 3);
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 1, 1);
    chk("a_both_hold", int'(ax), 3);
    chk("b_both_hold", int'(bx), 279);

    // Full jump: one pulse off-tick, then 14 ticks.
    do_cycle(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) begin
      do_cycle(1, 0, 0, 0);
      chk("a_jump_y", int'(ay), a_jump_y[i]);
      if (i < 8) chk("b_ceiling_y", int'(by), b_jump_y[i]);
    end
    chk("a_landed_air", int'(a_air), 0);

    // Same-cycle jump+tick from ground, then an airborne press that must be dropped.
    do_cycle(1, 1, 0, 0);
    chk("a_same_cycle_rise", int'(a_air), 1);
    do_cycle(0, 1, 0, 0);
    do_cycle(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) do_cycle(1, 0, 0, 0);
    chk("a_stays_ground_air", int'(a_air), 0);
    chk("a_stays_ground_y", int'(ay), 100);

    // frame_done: ticks at relative cycles 10, 11, 20.
    for (int c = 0; c < 23; c++) begin
      do_cycle((c == 10 || c == 11 || c == 20) ? 1 : 0, 0, 0, 0);
      chk("done_pattern", int'(a_done), (c == 10 || c == 11 || c == 20) ? 1 : 0);
    end

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 2) == 0) ? 1 : 0,
               ($urandom_range(0, 9) == 0) ? 1 : 0,
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a jump, away from any clock edge.
    do_cycle(1, 1, 0, 1);
    do_cycle(1, 0, 0, 1);
    do_cycle(1, 0, 0, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_a_x", int'(ax), 20);
    chk("arst_a_y", int'(ay), 100);
    chk("arst_a_air", int'(a_air), 0);
    chk("arst_a_done", int'(a_done), 0);
    chk("arst_b_x", int'(bx), 308);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
